down_rate_divider: RTL and testbench
====================================

Name: down_rate_divider

Overview:
- Loadable down-counter that mirrors the lab's 8-bit up-counter. It counts from a programmable start value down to zero.
- At zero it emits a one-cycle Pulse, then either reloads (periodic mode) or halts (one-shot mode).
- Serves as the rate divider / tick generator that drives slow counters and HEX displays elsewhere in the lab designs.

Parameters:
- WIDTH, 8: width of counter and LoadValue.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Clear_b  input  1  asynchronous, active-low reset.
- Enable  input  1  count enable; decrement/terminal action only when 1.
- Load  input  1  synchronous parallel load of LoadValue.
- LoadValue  input  WIDTH  start/reload value; sampled only on Load or on auto-reload.
- AutoReload  input  1  1 = periodic mode, 0 = one-shot mode.
- CounterValue  output  WIDTH  current count, registered.
- Pulse  output  1  registered one-cycle terminal-count strobe.
- Done  output  1  sticky; one-shot count has expired.

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is asynchronous, active-low on Clear_b. Clear_b=0 immediately forces CounterValue=0, Pulse=0, Done=0, regardless of Clock.
- Priority per rising edge, with Clear_b=1: Load > Enable > hold.
- Load=1:
  - CounterValue<=LoadValue, Pulse<=0, Done<=0.
  - Enable and AutoReload are ignored that cycle.
- Load=0, Enable=1, CounterValue!=0: CounterValue<=CounterValue-1, Pulse<=0.
- Load=0, Enable=1, CounterValue==0, AutoReload=1: CounterValue<=LoadValue, Pulse<=1.
- Load=0, Enable=1, CounterValue==0, AutoReload=0:
  - CounterValue holds 0.
  - If Done==0: Pulse<=1, Done<=1.
  - Otherwise: Pulse<=0.
  - Exactly one Pulse per expiry.
- Load=0, Enable=0: all state holds, Pulse<=0. Pulse is never stretched.
- Periodic timing:
  - With Enable held high, Pulse asserts once every LoadValue+1 cycles.
  - LoadValue=0 gives Pulse high every cycle.
  - LoadValue=all-ones gives a period of 2^WIDTH.
- Latency: Pulse is registered. It is high in the cycle after the edge at which CounterValue was observed as 0.
- No wrap: CounterValue never transitions 0 -> all-ones.
- Changes to LoadValue mid-count have no effect until the next Load or reload.
- AutoReload toggled mid-count takes effect at the next zero.
- Switching AutoReload 0->1 while Done=1 reloads on the next enabled edge, with Pulse=1. Done stays 1 until Load or reset.
- Reset asserted mid-count: same as power-up. After release, the counter sits at 0 with Done=0. In one-shot mode, the first enabled edge then produces a Pulse.

Decomposition:
- Shared package:
  - Mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
  - Default WIDTH.
- Natural sub-module: down_tff_cell.
  - A T flip-flop with async clear and synchronous load.
  - Toggles when Enable and all lower bits are 0 (borrow chain).
  - The counter is WIDTH instances plus the terminal/reload control.

Test Plan:
- Reset mid-count: Load 8'd5, count 2 cycles, pulse Clear_b low between edges -> CounterValue=0, Pulse=0, Done=0 immediately, without waiting for a clock edge.
- Periodic: LoadValue=3, AutoReload=1, Load then Enable high 12 cycles -> CounterValue 3,2,1,0,3,...; Pulse high exactly in cycles 4, 8, 12 after load (period 4).
- One-shot: LoadValue=2, AutoReload=0, Load, Enable high 6 cycles -> 2,1,0,0,0,0; single Pulse one cycle after reaching 0; Done=1 thereafter.
- Enable gating: LoadValue=4, toggle Enable 1,0,0,1,1 -> count 4,3,3,3,2,1; Pulse stays 0; hold cycles leave the count unchanged.
- Load priority: Load=1 and Enable=1 on the same edge with CounterValue=0, AutoReload=1, LoadValue=7 -> CounterValue=7, Pulse=0, Done cleared.
- Boundaries:
  - LoadValue=0, periodic -> Pulse=1 every enabled cycle.
  - LoadValue=8'hFF -> Pulse period 256.
  - Never observe 0 -> 8'hFF without a reload.

Source files
------------

// File: rtl/down_rate_divider_pkg.sv
// Shared definitions for the down_rate_divider tick generator.
package down_rate_divider_pkg;

   // Default counter / LoadValue width.
   localparam int unsigned DEFAULT_WIDTH = 8;

   // Behaviour at terminal count, selected by AutoReload.
   typedef enum logic {
      MODE_ONESHOT  = 1'b0,
      MODE_PERIODIC = 1'b1
   } mode_e;

endpackage : down_rate_divider_pkg

// File: rtl/down_rate_divider_if.sv
// Control/status bundle of the down_rate_divider.
// The master drives the controls, and the slave (the counter) returns its status.
interface down_rate_divider_if
   import down_rate_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             Enable;
   logic             Load;
   logic [WIDTH-1:0] LoadValue;
   logic             AutoReload;
   logic [WIDTH-1:0] CounterValue;
   logic             Pulse;
   logic             Done;

   modport master (
      output Enable, Load, LoadValue, AutoReload,
      input  CounterValue, Pulse, Done
   );

   modport slave (
      input  Enable, Load, LoadValue, AutoReload,
      output CounterValue, Pulse, Done
   );

endinterface : down_rate_divider_if

// File: rtl/down_rate_divider_tff_cell.sv
// One counter bit: a T flip-flop with asynchronous clear and synchronous load.
// Load takes precedence over toggle.
module down_tff_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic load_bit,
   input  logic toggle,
   output logic q
);

   logic q_q;
   logic q_d;

   // Next bit value: parallel load, otherwise toggle on request.
   always_comb begin
      q_d = load ? load_bit : (q_q ^ toggle);
   end

   // Bit storage with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= 1'b0;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule : down_tff_cell

// File: rtl/down_rate_divider.sv
// Loadable down-counter and tick generator.
// The counter counts from LoadValue to zero. At zero it strobes Pulse for one
// cycle, then either reloads (periodic mode) or halts with Done set (one-shot mode).
module down_rate_divider
   import down_rate_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               Clock,
   input  logic               Clear_b,
   down_rate_divider_if.slave bus
);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] toggle;
   logic             zero;
   logic             dec;
   logic             reload;
   logic             cell_load;
   logic             borrow;
   mode_e            mode;

   logic             pulse_q, pulse_d;
   logic             done_q,  done_d;

   assign zero = (count == '0);
   assign mode = mode_e'(bus.AutoReload);

   // Terminal-count control. Priority is Load, then Enable, then hold.
   always_comb begin
      dec     = 1'b0;
      reload  = 1'b0;
      pulse_d = 1'b0;
      done_d  = done_q;
      if (bus.Load) begin
         done_d = 1'b0;
      end else if (bus.Enable) begin
         if (!zero) begin
            dec = 1'b1;
         end else if (mode == MODE_PERIODIC) begin
            reload  = 1'b1;
            pulse_d = 1'b1;
         end else if (!done_q) begin
            pulse_d = 1'b1;
            done_d  = 1'b1;
         end
      end
   end

   assign cell_load = bus.Load | reload;

   // Borrow chain: a bit toggles on decrement when every lower bit is zero.
   always_comb begin
      toggle = '0;
      borrow = dec;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         toggle[i] = borrow;
         borrow    = borrow & ~count[i];
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      down_tff_cell u_cell (
         .clk      (Clock),
         .rst_n    (Clear_b),
         .load     (cell_load),
         .load_bit (bus.LoadValue[g]),
         .toggle   (toggle[g]),
         .q        (count[g])
      );
   end

   // Registered strobe and sticky expiry flag.
   always_ff @(posedge Clock or negedge Clear_b) begin
      if (!Clear_b) begin
         pulse_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         pulse_q <= pulse_d;
         done_q  <= done_d;
      end
   end

   assign bus.CounterValue = count;
   assign bus.Pulse        = pulse_q;
   assign bus.Done         = done_q;

endmodule : down_rate_divider

// File: tb/tb_down_rate_divider.sv
// Scoreboard bench for down_rate_divider (WIDTH = 8).
// The stimulus pushes the expected post-edge state, and the monitor pops and compares.
module tb_down_rate_divider;

   logic Clock;
   logic Clear_b;

   down_rate_divider_if #(.WIDTH(8)) bus ();

   down_rate_divider #(.WIDTH(8)) dut (
      .Clock   (Clock),
      .Clear_b (Clear_b),
      .bus     (bus)
   );

   typedef struct {
      logic [7:0] cnt;
      logic       pulse;
      logic       done;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [7:0] c, input logic p, input logic d,
                        input logic [7:0] ec, input logic ep, input logic ed);
      n_checks++;
      if ({c, p, d} !== {ec, ep, ed}) begin
         n_errors++;
         $display("FAIL %s: got cnt=%0h pulse=%0b done=%0b, expected cnt=%0h pulse=%0b done=%0b",
                  nm, c, p, d, ec, ep, ed);
      end
   endtask

   // Drive one cycle of inputs, then queue the state expected after the next rising edge.
   task automatic step(input logic ld, input logic en, input logic ar, input logic [7:0] lv,
                       input logic [7:0] ec, input logic ep, input logic ed, input string nm);
      exp_t e;
      @(negedge Clock);
      bus.Load       = ld;
      bus.Enable     = en;
      bus.AutoReload = ar;
      bus.LoadValue  = lv;
      e.cnt   = ec;
      e.pulse = ep;
      e.done  = ed;
      e.name  = nm;
      sb.push_back(e);
   endtask

   // Monitor: compare each queued expectation just after the edge it belongs to.
   initial begin
      forever begin
         @(posedge Clock);
         #1;
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check(mon_e.name, bus.CounterValue, bus.Pulse, bus.Done,
                  mon_e.cnt, mon_e.pulse, mon_e.done);
         end
      end
   end

   initial begin
      Clear_b        = 1'b0;
      bus.Load       = 1'b0;
      bus.Enable     = 1'b0;
      bus.AutoReload = 1'b0;
      bus.LoadValue  = 8'd0;
      #2;
      check("reset_state", bus.CounterValue, bus.Pulse, bus.Done, 8'd0, 1'b0, 1'b0);
      @(negedge Clock);
      Clear_b = 1'b1;

      // Asynchronous reset in the middle of a count.
      step(1'b1, 1'b0, 1'b0, 8'd5, 8'd5, 1'b0, 1'b0, "rst_load5");
      step(1'b0, 1'b1, 1'b0, 8'd5, 8'd4, 1'b0, 1'b0, "rst_cnt1");
      step(1'b0, 1'b1, 1'b0, 8'd5, 8'd3, 1'b0, 1'b0, "rst_cnt2");
      @(negedge Clock);
      bus.Enable = 1'b0;
      #2 Clear_b = 1'b0;
      #1 check("async_clear", bus.CounterValue, bus.Pulse, bus.Done, 8'd0, 1'b0, 1'b0);
      @(posedge Clock);
      #1 check("clear_held", bus.CounterValue, bus.Pulse, bus.Done, 8'd0, 1'b0, 1'b0);
      @(negedge Clock);
      Clear_b = 1'b1;

      // After reset in one-shot mode, the first enabled edge produces a pulse.
      step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, "oneshot_after_reset");
      step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, "oneshot_no_repeat");

      // Periodic mode with LoadValue=3 gives a period of 4.
      step(1'b1, 1'b0, 1'b1, 8'd3, 8'd3, 1'b0, 1'b0, "per_load");
      for (int k = 1; k <= 12; k++)
         step(1'b0, 1'b1, 1'b1, 8'd3, 8'(3 - (k % 4)), (k % 4) == 0, 1'b0, "per_count");

      // One-shot mode with LoadValue=2.
      step(1'b1, 1'b0, 1'b0, 8'd2, 8'd2, 1'b0, 1'b0, "os_load");
      step(1'b0, 1'b1, 1'b0, 8'd2, 8'd1, 1'b0, 1'b0, "os_c1");
      step(1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0, "os_c2");
      step(1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 1'b1, 1'b1, "os_expire");
      step(1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b1, "os_no_wrap1");
      step(1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b1, "os_no_wrap2");
      step(1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b1, "os_no_wrap3");

      // Switching to periodic while Done=1 reloads with a pulse. Done stays set.
      step(1'b0, 1'b1, 1'b1, 8'd2, 8'd2, 1'b1, 1'b1, "ar_switch_reload");
      step(1'b0, 1'b0, 1'b1, 8'd2, 8'd2, 1'b0, 1'b1, "hold_no_stretch");
      step(1'b0, 1'b1, 1'b1, 8'd2, 8'd1, 1'b0, 1'b1, "done_sticky");

      // Enable gating. A LoadValue change mid-count is ignored.
      step(1'b1, 1'b0, 1'b1, 8'd4, 8'd4, 1'b0, 1'b0, "gate_load");
      step(1'b0, 1'b1, 1'b1, 8'd9, 8'd3, 1'b0, 1'b0, "gate_en1");
      step(1'b0, 1'b0, 1'b1, 8'd9, 8'd3, 1'b0, 1'b0, "gate_hold1");
      step(1'b0, 1'b0, 1'b1, 8'd9, 8'd3, 1'b0, 1'b0, "gate_hold2");
      step(1'b0, 1'b1, 1'b1, 8'd9, 8'd2, 1'b0, 1'b0, "gate_en2");
      step(1'b0, 1'b1, 1'b1, 8'd9, 8'd1, 1'b0, 1'b0, "gate_en3");

      // Load wins over Enable at zero in periodic mode and clears Done.
      step(1'b0, 1'b1, 1'b0, 8'd9, 8'd0, 1'b0, 1'b0, "lp_reach0");
      step(1'b0, 1'b1, 1'b0, 8'd9, 8'd0, 1'b1, 1'b1, "lp_expire");
      step(1'b1, 1'b1, 1'b1, 8'd7, 8'd7, 1'b0, 1'b0, "load_priority");

      // LoadValue=0 in periodic mode pulses on every enabled cycle.
      step(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, "lv0_load");
      for (int k = 0; k < 4; k++)
         step(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, "lv0_pulse");

      // LoadValue=FF gives a period of 256 and reloads from 0 to FF only on reload.
      step(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, "ff_load");
      for (int k = 1; k <= 258; k++)
         step(1'b0, 1'b1, 1'b1, 8'hFF,
              (k <= 255) ? 8'(255 - k) : 8'(255 - (k - 256)), k == 256, 1'b0, "ff_count");
      step(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFD, 1'b0, 1'b0, "final_hold");

      // Drain the scoreboard with a bounded wait.
      for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge Clock);
      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_down_rate_divider
